oh_clockdiv_ctrl: RTL
=====================

# oh_clockdiv_ctrl

Reconfiguration sequencer for the `oh_clockdiv` clock divider. It accepts divider settings over a valid/ready request port and applies them glitch-safely:

1. Gate the divider counter.
2. Load the new ratio and phases, and pulse `clkchange`.
3. Run the divider until it reports `clkstable`, or until a timeout expires.

It sits between the register file / software interface and the divider, and owns every divider control input.

## Interface
Parameters:
- `QUIESCE`, 4 — cycles `div_clken` is held low before new settings load (≥1).
- `TIMEOUT`, 4096 — maximum WAIT cycles before the sequence aborts with error (≥1). 4096 covers 8 periods at div 256.

Ports:
- `clk` in 1 — single clock; drives the divider too.
- `reset` in 1 — asynchronous, active-high reset.
- `enable` in 1 — software clock enable. Drives `div_clken` only while in IDLE.
- `req_valid` in 1 — configuration request.
- `req_ready` out 1 — high in IDLE only; transfer occurs when `req_valid & req_ready`.
- `req_div` in 8 — new clkdiv (0 = bypass, N = divide by N+1).
- `req_auto` in 1 — 1: phases computed internally; 0: `req_phase0`/`req_phase1` used verbatim.
- `req_phase0` in 16, `req_phase1` in 16 — manual phases, [7:0] rise, [15:8] fall.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — one-cycle pulse at sequence end.
- `error` out 1 — valid with `done`: 1 = timeout. Low otherwise.
- `div_clken` out 1, `div_clkchange` out 1 — to divider.
- `div_clkdiv` out 8, `div_clkphase0` out 16, `div_clkphase1` out 16 — to divider; all registered.
- `div_clkstable` in 1 — from divider.

## Operation
States are IDLE, GATE, LOAD, WAIT and DONE.

- **IDLE**
  - `div_clken` = `enable`.
  - On handshake, capture `req_div`/`req_auto`/phases into shadow registers and go to GATE. Clear the quiesce counter.
  - `req_valid` outside IDLE is ignored (not queued).
- **GATE**
  - `div_clken` = 0.
  - Count QUIESCE cycles, then go to LOAD.
- **LOAD** (exactly 1 cycle)
  - `div_clkdiv`/`div_clkphase*` take the shadow values on entry.
  - `div_clkchange` = 1.
  - `div_clken` = 0.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - `div_clken` = 1, regardless of `enable`.
  - If `div_clkstable` = 1, go to DONE with error = 0.
  - Else, when the timeout counter reaches TIMEOUT, go to DONE with error = 1.
  - `div_clkstable` is not sampled in LOAD. The divider clears it at the LOAD edge.
- **DONE** (1 cycle)
  - `done` = 1, `error` per WAIT outcome, `div_clken` = 1.
  - Next state is IDLE.
- **Settings retention:** settings are retained after a timeout. There is no rollback.
- **Auto phase arithmetic:** P = {1'b0, D} + 1, 9-bit, where D = `req_div`.
  - D = 0: both phases = 16'h0000.
  - Otherwise:
    - phase0 rise = 0, fall = P>>1.
    - phase1 rise = P>>2, fall = (P>>2) + (P>>1).
  - All results fit 8 bits; the max is 192 at D = 255.
- **Identical settings:** a request with settings identical to the current ones still runs the full sequence.
- **Mid-sequence `enable` changes:** changes to `enable` mid-sequence take effect on return to IDLE.

## Timing
- **Reset values** (asynchronous; state forced to IDLE):
  - `div_clken` = 0 while reset is high; it follows `enable` from the first cycle after deassertion.
  - `div_clkchange` = 0, `div_clkdiv` = 8'h00, phases = 16'h0000.
  - `busy` = 0, `done` = 0, `error` = 0.
  - `req_ready` = 0 while reset is high, 1 after.
- **Cycle schedule:** with the handshake at the end of cycle 0:
  - GATE spans cycles 1..QUIESCE.
  - LOAD is cycle QUIESCE+1.
  - WAIT spans cycles QUIESCE+2..QUIESCE+1+W (W ≥ 1).
  - DONE is cycle QUIESCE+2+W.
  - `req_ready` is high again in cycle QUIESCE+3+W.
- **Timeout:** W = TIMEOUT exactly.
- **Reset mid-operation:** reset in any state aborts with no `done` pulse and restores reset values.
- **Output timing:** `div_clkchange` is high for exactly one cycle per sequence, coincident with the first cycle of the new settings.

## Test plan
- **Auto, D=3, QUIESCE=4, divider model attached:** request → LOAD in cycle 5 shows `div_clkdiv`=3, `div_clkphase0`=16'h0200, `div_clkphase1`=16'h0301, `div_clkchange`=1. `done`=1 with `error`=0 after `div_clkstable` rises (~32 WAIT cycles). `div_clken` is 0 in cycles 1–5.
- **Bypass, D=0:** phases = 16'h0000 in LOAD. Stable after 8 WAIT cycles → `done`, `error`=0.
- **Timeout:** TIMEOUT=64, `div_clkstable` tied 0 → `done`=`error`=1 exactly in cycle QUIESCE+66. Settings stay loaded and `req_ready` returns.
- **Manual mode:** `req_auto`=0, phases 16'h0502/16'h0604 with D=7 → driven verbatim. A second `req_valid` during WAIT is ignored: `req_ready`=0 and no second `div_clkchange`.
- **Reset during WAIT:** all outputs return to reset values immediately (async), with no `done`. A new request after reset completes normally.
- **`enable` toggled mid-sequence:** no effect on `div_clken` until IDLE, after which `div_clken` tracks `enable` in the same cycle.

Source files
------------

// File: rtl/oh_clockdiv_ctrl.sv
// Reconfiguration sequencer for oh_clockdiv. It gates the divider, loads the
// new ratio and phases with a clkchange pulse, then waits for clkstable.
module oh_clockdiv_ctrl #(
    parameter int QUIESCE = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_div,
    input  logic        req_auto,
    input  logic [15:0] req_phase0,
    input  logic [15:0] req_phase1,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        div_clken,
    output logic        div_clkchange,
    output logic [7:0]  div_clkdiv,
    output logic [15:0] div_clkphase0,
    output logic [15:0] div_clkphase1,
    input  logic        div_clkstable
);
    localparam int QW = (QUIESCE > 1) ? $clog2(QUIESCE) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QUIESCE - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATE,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [QW-1:0] r_qcnt;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_sh_div;
    logic [15:0]   r_sh_ph0;
    logic [15:0]   r_sh_ph1;
    logic          r_done;
    logic          r_error;
    logic          r_clkchange;
    logic [31:0]   w_auto_ph;

    // Returns {phase1, phase0}, each {fall, rise}, with P = D + 1 in 9 bits.
    function automatic logic [31:0] auto_phases(input logic [7:0] d);
        logic [8:0] p;
        logic [7:0] half;
        logic [7:0] quarter;
        p       = {1'b0, d} + 9'd1;
        half    = 8'(p >> 1);
        quarter = 8'(p >> 2);
        if (d == 8'd0) begin
            return 32'h0000_0000;
        end
        return {quarter + half, quarter, half, 8'h00};
    endfunction

    assign w_auto_ph = auto_phases(req_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_qcnt        <= '0;
            r_tcnt        <= '0;
            r_sh_div      <= 8'h00;
            r_sh_ph0      <= 16'h0000;
            r_sh_ph1      <= 16'h0000;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_clkchange   <= 1'b0;
            div_clkdiv    <= 8'h00;
            div_clkphase0 <= 16'h0000;
            div_clkphase1 <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_sh_div <= req_div;
                        r_sh_ph0 <= req_auto ? w_auto_ph[15:0]  : req_phase0;
                        r_sh_ph1 <= req_auto ? w_auto_ph[31:16] : req_phase1;
                        r_qcnt   <= '0;
                        r_state  <= S_GATE;
                    end
                end
                S_GATE: begin
                    if (r_qcnt == QLAST) begin
                        div_clkdiv    <= r_sh_div;
                        div_clkphase0 <= r_sh_ph0;
                        div_clkphase1 <= r_sh_ph1;
                        r_clkchange   <= 1'b1;
                        r_state       <= S_LOAD;
                    end else begin
                        r_qcnt <= r_qcnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    r_clkchange <= 1'b0;
                    r_tcnt      <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // Stability wins over a timeout landing in the same cycle.
                    if (div_clkstable) begin
                        r_done  <= 1'b1;
                        r_error <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_tcnt == TLAST) begin
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Reset is folded in so the divider and requester see it without waiting for an edge.
    assign req_ready     = (r_state == S_IDLE) & ~reset;
    assign div_clken     = (r_state == S_IDLE) ? (enable & ~reset)
                                               : ((r_state == S_WAIT) || (r_state == S_DONE));
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign error         = r_error;
    assign div_clkchange = r_clkchange;

endmodule
